spm_bank_conflict_scheduler: RTL
================================

Name: spm_bank_conflict_scheduler

Overview:
- Sequences one scratchpad vector access (one request per processing element) through the per-bank input interconnect.
- Each cycle it presents a conflict-free subset of pending lanes as the satisfied mask. At most one bank address is used per bank per cycle; loads to an identical bank/offset are merged.
- Iterates until every lane in the request mask has been issued, then accepts the next request.
- Sits between the SPM request stage and the input interconnect/bank array.

Parameters:
- NUM_PE, `SM_PROCESSING_ELEMENTS (16): number of requesting lanes.
- NUM_BANKS, `SM_MEMORY_BANKS (16): number of memory banks.
- CNT_W, $clog2(NUM_PE)+1: width of the issue-cycle counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  new vector request present.
- in_ready  out  1  scheduler can accept a request.
- in_mask  in  NUM_PE  active lanes.
- in_is_store  in  1  request is a store (whole vector).
- in_bank_indexes  in  NUM_PE x sm_bank_address_t  per-lane bank.
- in_bank_offsets  in  NUM_PE x sm_entry_address_t  per-lane entry.
- in_data  in  NUM_PE x sm_data_t  per-lane store data.
- in_byte_mask  in  NUM_PE x sm_byte_mask_t  per-lane byte enables.
- out_valid  out  1  issue slot valid.
- out_ready  in  1  banks accept this slot.
- out_satisfied_mask  out  NUM_PE  lanes issued this slot.
- out_is_store  out  1  latched in_is_store.
- out_bank_indexes / out_bank_offsets / out_data / out_byte_mask  out  as inputs  latched request fields.
- out_last  out  1  this slot completes the request.
- out_issue_count  out  CNT_W  index of the current slot (0-based).

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, pending=0, out_valid=0, out_last=0, out_satisfied_mask=0, out_issue_count=0, all latched fields=0.
  - in_ready=0 while reset is low.
  - Reset mid-operation discards the request without completion.
- States: IDLE, ISSUE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch all in_* fields, pending<=in_mask, out_issue_count<=0, go to ISSUE.
  - First out_valid appears the cycle after acceptance.
- Grant function (combinational from registered pending and latched fields):
  - For each bank b, winner w(b) = lowest-index pending lane with bank_index==b.
  - Lane j is granted iff pending[j] and bank(j)==b and one of:
    - j==w(b), or
    - !is_store and offset(j)==offset(w(b)).
  - out_satisfied_mask = OR of grants over all banks.
  - At most one distinct offset per bank per slot.
  - Stores never merge: same-address stores are serialized lowest lane first, so the highest lane's data remains in memory.
- ISSUE:
  - out_valid=1; out_last=((pending & ~out_satisfied_mask)==0).
  - out_valid&&out_ready: pending<=pending&~out_satisfied_mask, out_issue_count++. If out_last, go to IDLE.
  - !out_ready: hold pending, mask and fields stable (no progress, no counter change).
  - in_ready=0 throughout ISSUE. Back-to-back requests therefore incur one IDLE cycle.
- Zero in_mask: accepted normally. A single ISSUE slot follows with out_satisfied_mask=0 and out_last=1.
- Slot count:
  - Stores: max over banks of the number of pending lanes on that bank.
  - Loads: max over banks of the number of distinct offsets on that bank.
  - Bounded by NUM_PE; out_issue_count never exceeds NUM_PE-1 and never wraps.
- Latched fields are held unchanged from acceptance until the next acceptance.

Decomposition:
- npu_spm_defines.sv already provides sm_bank_address_t, sm_entry_address_t, sm_data_t, sm_byte_mask_t, `SM_PROCESSING_ELEMENTS and `SM_MEMORY_BANKS.
- Add to that package:
  - typedef sm_sched_state_t {IDLE, ISSUE}
  - typedef sm_pe_mask_t = logic[`SM_PROCESSING_ELEMENTS-1:0]
- One combinational sub-module, spm_bank_grant_unit (per-bank winner and merge logic), is instantiated once per bank under generate. The scheduler ORs the per-bank grant vectors.

Test Plan:
- Distinct banks: all 16 lanes on banks 0..15, load, out_ready=1 → one slot with mask=16'hFFFF, out_last=1, out_issue_count=0; in_ready returns 2 cycles after acceptance.
- Bank-conflict stores: all lanes on bank 3 with offsets 0..15 → 16 slots with masks 0x0001, 0x0002, …, 0x8000; out_last only on the 16th slot.
- Load broadcast: all lanes on bank 5, offset 7, load → one slot, mask=16'hFFFF. The same stimulus as a store → 16 single-lane slots in ascending lane order.
- Mixed loads: lanes 0–3 on bank 1 with offsets {2,2,9,2}, others on unique banks → slot0 mask=16'hFFFB, slot1 mask=16'h0004, last.
- Backpressure and empty request: out_ready=0 for 3 cycles mid-sequence → mask, fields and out_issue_count stable and no lane lost. in_mask=0 → one slot, mask=0, out_last=1.
- Reset: reset low during slot 2 of the 16-slot store case → next cycle out_valid=0; after release in_ready=1 and pending is empty. A new request then completes normally.

Source files
------------

// File: rtl/spm_bank_conflict_scheduler_pkg.sv
// Shared types for the scratchpad bank-conflict scheduler.
//   - Scratchpad geometry (lanes, banks) and per-lane field types.
//   - sm_sched_state_t : scheduler FSM states.
//   - sm_pe_mask_t     : one bit per processing element.
`ifndef SM_PROCESSING_ELEMENTS
`define SM_PROCESSING_ELEMENTS 16
`endif
`ifndef SM_MEMORY_BANKS
`define SM_MEMORY_BANKS 16
`endif

package spm_bank_conflict_scheduler_pkg;

    localparam int SM_PROCESSING_ELEMENTS = `SM_PROCESSING_ELEMENTS;
    localparam int SM_MEMORY_BANKS        = `SM_MEMORY_BANKS;

    typedef logic [$clog2(`SM_MEMORY_BANKS)-1:0] sm_bank_address_t;
    typedef logic [7:0]                          sm_entry_address_t;
    typedef logic [31:0]                         sm_data_t;
    typedef logic [3:0]                          sm_byte_mask_t;

    typedef enum logic {IDLE, ISSUE} sm_sched_state_t;

    typedef logic [`SM_PROCESSING_ELEMENTS-1:0] sm_pe_mask_t;

endpackage

// File: rtl/spm_bank_conflict_scheduler_bank_grant.sv
// spm_bank_grant_unit: combinational grant logic for one memory bank.
//   pending      in  lanes still waiting to be issued
//   is_store     in  request is a store (disables address merging)
//   bank_indexes in  per-lane bank
//   bank_offsets in  per-lane entry within the bank
//   grant        out lanes this bank serves in the current slot
// The lowest pending lane targeting this bank wins the bank. For loads,
// every other pending lane reading the same entry rides along with it.
module spm_bank_grant_unit
    import spm_bank_conflict_scheduler_pkg::*;
#(
    parameter int NUM_PE  = SM_PROCESSING_ELEMENTS,
    parameter int BANK_ID = 0
) (
    input  logic [NUM_PE-1:0]                    pending,
    input  logic                                 is_store,
    input  sm_bank_address_t  [NUM_PE-1:0]       bank_indexes,
    input  sm_entry_address_t [NUM_PE-1:0]       bank_offsets,
    output logic [NUM_PE-1:0]                    grant
);

    localparam sm_bank_address_t BANK = sm_bank_address_t'(BANK_ID);

    logic              found;
    sm_entry_address_t win_offset;

    always_comb begin
        found      = 1'b0;
        win_offset = '0;
        grant      = '0;
        // Ascending scan: the first hit is the winner and fixes the entry
        // this bank serves in the slot.
        for (int j = 0; j < NUM_PE; j++) begin
            if (pending[j] && (bank_indexes[j] == BANK)) begin
                if (!found) begin
                    found      = 1'b1;
                    win_offset = bank_offsets[j];
                    grant[j]   = 1'b1;
                end else if (!is_store && (bank_offsets[j] == win_offset)) begin
                    grant[j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spm_bank_conflict_scheduler.sv
// spm_bank_conflict_scheduler: splits one vector scratchpad access into
// conflict-free issue slots (at most one entry per bank per slot).
//   clk, reset (sync, active-low)
//   in_valid/in_ready            request handshake, in_* fields latched on accept
//   out_valid/out_ready          issue-slot handshake
//   out_satisfied_mask           lanes issued in the current slot
//   out_last                     current slot finishes the request
//   out_issue_count              0-based slot index
//   out_is_store, out_bank_indexes, out_bank_offsets, out_data,
//   out_byte_mask                latched request fields
module spm_bank_conflict_scheduler
    import spm_bank_conflict_scheduler_pkg::*;
#(
    parameter int NUM_PE    = SM_PROCESSING_ELEMENTS,
    parameter int NUM_BANKS = SM_MEMORY_BANKS,
    parameter int CNT_W     = $clog2(NUM_PE) + 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_PE-1:0]                 in_mask,
    input  logic                              in_is_store,
    input  sm_bank_address_t  [NUM_PE-1:0]    in_bank_indexes,
    input  sm_entry_address_t [NUM_PE-1:0]    in_bank_offsets,
    input  sm_data_t          [NUM_PE-1:0]    in_data,
    input  sm_byte_mask_t     [NUM_PE-1:0]    in_byte_mask,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_PE-1:0]                 out_satisfied_mask,
    output logic                              out_is_store,
    output sm_bank_address_t  [NUM_PE-1:0]    out_bank_indexes,
    output sm_entry_address_t [NUM_PE-1:0]    out_bank_offsets,
    output sm_data_t          [NUM_PE-1:0]    out_data,
    output sm_byte_mask_t     [NUM_PE-1:0]    out_byte_mask,
    output logic                              out_last,
    output logic [CNT_W-1:0]                  out_issue_count
);

    sm_sched_state_t     state;
    logic [NUM_PE-1:0]   pending;
    logic [NUM_PE-1:0]   bank_grant [NUM_BANKS];
    logic [NUM_PE-1:0]   grant_any;

    genvar b;
    generate
        for (b = 0; b < NUM_BANKS; b++) begin : g_bank
            spm_bank_grant_unit #(
                .NUM_PE  (NUM_PE),
                .BANK_ID (b)
            ) u_grant (
                .pending      (pending),
                .is_store     (out_is_store),
                .bank_indexes (out_bank_indexes),
                .bank_offsets (out_bank_offsets),
                .grant        (bank_grant[b])
            );
        end
    endgenerate

    always_comb begin
        grant_any = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            grant_any = grant_any | bank_grant[i];
        end
    end

    // in_ready is forced low while reset is asserted, not just after it.
    assign in_ready           = reset && (state == IDLE);
    assign out_valid          = (state == ISSUE);
    assign out_satisfied_mask = (state == ISSUE) ? grant_any : '0;
    assign out_last           = (state == ISSUE) && ((pending & ~grant_any) == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            pending          <= '0;
            out_issue_count  <= '0;
            out_is_store     <= 1'b0;
            out_bank_indexes <= '0;
            out_bank_offsets <= '0;
            out_data         <= '0;
            out_byte_mask    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        pending          <= in_mask;
                        out_issue_count  <= '0;
                        out_is_store     <= in_is_store;
                        out_bank_indexes <= in_bank_indexes;
                        out_bank_offsets <= in_bank_offsets;
                        out_data         <= in_data;
                        out_byte_mask    <= in_byte_mask;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (out_ready) begin
                        pending <= pending & ~grant_any;
                        // The counter stops on the final slot so it never
                        // exceeds NUM_PE-1.
                        if (out_last) begin
                            state <= IDLE;
                        end else begin
                            out_issue_count <= out_issue_count + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
